load_store_unit: RTL and testbench

Memory-stage initiator for the word-addressed data memory. Accepts byte/halfword/word load and store requests from the pipeline MEM stage over a valid/ready handshake and drives the data memory's Address/WriteData/MemoryRead/MemoryWrite port. It absorbs the memory's registered-read latency, performs sub-word extraction with sign/zero extension, and implements sub-word stores as read-modify-write. It returns one response per request with an error flag.

---
 rtl/lsu_pkg.sv | 38 +++
 rtl/lsu_lane_align.sv | 63 ++++++
 rtl/load_store_unit.sv | 125 ++++++++++++
 tb/tb_load_store_unit.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load/store unit.
//   lsu_state_e : transaction state machine encoding
//   lsu_size_e  : request size encodings (byte / half / word / illegal)
//   LSU_ADDR_W  : default memory word-address width
//   lsu_misaligned : alignment check for a size/byte-lane pair
package lsu_pkg;

  localparam int unsigned LSU_ADDR_W = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_WR,
    S_RESP
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } lsu_size_e;

  // Illegal size counts as misaligned so one test covers both rejects.
  function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] lane);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lane[0];
      SZ_WORD: bad = (lane != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational sub-word lane handling.
//   rd_word  in  32  word read from memory
//   wdata    in  32  right-aligned store data
//   lane     in  2   byte address bits [1:0]
//   size     in  2   SZ_BYTE / SZ_HALF / SZ_WORD
//   sext     in  1   sign-extend sub-word loads
//   rdata    out 32  extracted and extended load data
//   merged   out 32  rd_word with the addressed lane(s) replaced by wdata
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        sext,
  output logic [31:0] rdata,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = '0;
    case (lane)
      2'd0: byte_sel = rd_word[7:0];
      2'd1: byte_sel = rd_word[15:8];
      2'd2: byte_sel = rd_word[23:16];
      default: byte_sel = rd_word[31:24];
    endcase
    half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];
  end

  always_comb begin
    rdata = '0;
    case (size)
      SZ_BYTE: rdata = {{24{sext & byte_sel[7]}}, byte_sel};
      SZ_HALF: rdata = {{16{sext & half_sel[15]}}, half_sel};
      default: rdata = rd_word;
    endcase
  end

  always_comb begin
    merged = rd_word;
    case (size)
      SZ_BYTE: begin
        case (lane)
          2'd0: merged[7:0]   = wdata[7:0];
          2'd1: merged[15:8]  = wdata[7:0];
          2'd2: merged[23:16] = wdata[7:0];
          default: merged[31:24] = wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        if (lane[1]) merged[31:16] = wdata[15:0];
        else         merged[15:0]  = wdata[15:0];
      end
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage initiator for a word-addressed data memory.
// Byte/half/word loads and stores over a valid/ready request channel, one
// response per request. Sub-word stores are done as read-modify-write.
//   Clock, Reset_n                 clock, async active-low reset
//   ReqValid/ReqReady              request handshake (ready only in IDLE)
//   ReqWrite/ReqSize/ReqSigned     request kind, size, load sign extension
//   ReqAddr/ReqWData               byte address, right-aligned store data
//   RespValid/RespReady            response handshake (valid only in RESP)
//   RespRData/RespError            load result, reject flag
//   MemAddress/MemWriteData        registered word address / write word
//   MemoryRead/MemoryWrite         strobes decoded from state
//   MemReadData                    registered memory read data
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = LSU_ADDR_W
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic              ReqWrite,
  input  logic [1:0]        ReqSize,
  input  logic              ReqSigned,
  input  logic [31:0]       ReqAddr,
  input  logic [31:0]       ReqWData,
  output logic              RespValid,
  input  logic              RespReady,
  output logic [31:0]       RespRData,
  output logic              RespError,
  output logic [ADDR_W-1:0] MemAddress,
  output logic [31:0]       MemWriteData,
  output logic              MemoryRead,
  output logic              MemoryWrite,
  input  logic [31:0]       MemReadData
);

  lsu_state_e  state;
  logic        write_q;
  lsu_size_e   size_q;
  logic        signed_q;
  logic [1:0]  lane_q;
  logic [31:0] wdata_q;

  logic        req_bad;
  logic [31:0] ext_data;
  logic [31:0] merged_data;

  // Strobes come straight from the state register, so an asynchronous reset
  // in WR drops MemoryWrite before the memory's falling-edge write.
  assign ReqReady    = (state == S_IDLE);
  assign RespValid   = (state == S_RESP);
  assign MemoryRead  = (state == S_RD);
  assign MemoryWrite = (state == S_WR);

  assign req_bad = lsu_misaligned(ReqSize, ReqAddr[1:0]) ||
                   ((ReqAddr >> (ADDR_W + 2)) != '0);

  lsu_lane_align u_align (
    .rd_word (MemReadData),
    .wdata   (wdata_q),
    .lane    (lane_q),
    .size    (size_q),
    .sext    (signed_q),
    .rdata   (ext_data),
    .merged  (merged_data)
  );

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state        <= S_IDLE;
      write_q      <= 1'b0;
      size_q       <= SZ_BYTE;
      signed_q     <= 1'b0;
      lane_q       <= '0;
      wdata_q      <= '0;
      MemAddress   <= '0;
      MemWriteData <= '0;
      RespRData    <= '0;
      RespError    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ReqValid) begin
            RespRData <= '0;
            if (req_bad) begin
              RespError <= 1'b1;
              state     <= S_RESP;
            end else begin
              RespError  <= 1'b0;
              write_q    <= ReqWrite;
              size_q     <= lsu_size_e'(ReqSize);
              signed_q   <= ReqSigned;
              lane_q     <= ReqAddr[1:0];
              wdata_q    <= ReqWData;
              MemAddress <= ReqAddr[ADDR_W+1:2];
              if (ReqWrite && (ReqSize == SZ_WORD)) begin
                MemWriteData <= ReqWData;
                state        <= S_WR;
              end else begin
                state <= S_RD;
              end
            end
          end
        end
        S_RD: state <= S_WAIT;
        S_WAIT: begin
          if (write_q) begin
            MemWriteData <= merged_data;
            state        <= S_WR;
          end else begin
            RespRData <= ext_data;
            state     <= S_RESP;
          end
        end
        S_WR: state <= S_RESP;
        S_RESP: begin
          if (RespReady) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        Clock;
  logic        Reset_n;
  logic        ReqValid;
  logic        ReqReady;
  logic        ReqWrite;
  logic [1:0]  ReqSize;
  logic        ReqSigned;
  logic [31:0] ReqAddr;
  logic [31:0] ReqWData;
  logic        RespValid;
  logic        RespReady;
  logic [31:0] RespRData;
  logic        RespError;
  logic [5:0]  MemAddress;
  logic [31:0] MemWriteData;
  logic        MemoryRead;
  logic        MemoryWrite;
  logic [31:0] MemReadData;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [31:0] mem    [64];
  logic [31:0] shadow [64];

  load_store_unit #(.ADDR_W(6)) dut (
    .Clock        (Clock),
    .Reset_n      (Reset_n),
    .ReqValid     (ReqValid),
    .ReqReady     (ReqReady),
    .ReqWrite     (ReqWrite),
    .ReqSize      (ReqSize),
    .ReqSigned    (ReqSigned),
    .ReqAddr      (ReqAddr),
    .ReqWData     (ReqWData),
    .RespValid    (RespValid),
    .RespReady    (RespReady),
    .RespRData    (RespRData),
    .RespError    (RespError),
    .MemAddress   (MemAddress),
    .MemWriteData (MemWriteData),
    .MemoryRead   (MemoryRead),
    .MemoryWrite  (MemoryWrite),
    .MemReadData  (MemReadData)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [31:0] init_word(input logic [5:0] i);
    return {8'hA5, 2'b00, i, 8'h5A, 2'b11, ~i};
  endfunction

  // Data memory: registered read, falling-edge write.
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = init_word(6'(i));
    forever begin
      @(negedge Clock);
      if (MemoryWrite) mem[MemAddress] = MemWriteData;
    end
  end

  always @(posedge Clock) if (MemoryRead) MemReadData <= mem[MemAddress];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ref_load(input logic [31:0] wd, input logic [1:0] ln,
                                           input logic [1:0] sz, input logic sg);
    logic [31:0] sh;
    if (sz == 2'd0) begin
      sh = wd >> {ln, 3'b000};
      return {(sg && sh[7]) ? 24'hFFFFFF : 24'h0, sh[7:0]};
    end
    if (sz == 2'd1) begin
      sh = wd >> {ln[1], 4'b0000};
      return {(sg && sh[15]) ? 16'hFFFF : 16'h0, sh[15:0]};
    end
    return wd;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [31:0] wd,
                                            input logic [1:0] ln, input logic [1:0] sz);
    logic [31:0] mask;
    logic [4:0]  sa;
    if (sz == 2'd0) begin
      sa = {ln, 3'b000};
      mask = 32'h0000_00FF << sa;
    end else if (sz == 2'd1) begin
      sa = {ln[1], 4'b0000};
      mask = 32'h0000_FFFF << sa;
    end else begin
      sa = 5'd0;
      mask = 32'hFFFF_FFFF;
    end
    return (old & ~mask) | ((wd << sa) & mask);
  endfunction

  function automatic logic ref_err(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) ||
           (a >= 32'd256);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called and returns at a falling edge. exp_lat counts rising edges from
  // the accept edge to the first edge at which RespValid is seen high.
  task automatic do_req(input string tag, input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic exp_err, input logic [31:0] exp_rd,
                        input int exp_lat, input int hold);
    int lat;
    int nrd;
    int nwr;
    int both;
    logic [5:0]  wa;
    logic [31:0] held;
    check({tag, ".ready"}, 32'(ReqReady), 32'd1);
    ReqValid = 1'b1; ReqWrite = w; ReqSize = sz; ReqSigned = sg;
    ReqAddr = addr; ReqWData = wd;
    @(posedge Clock);
    #1;
    // Scramble request inputs: the unit must use its latched copy.
    ReqValid = 1'b0; ReqWrite = ~w; ReqSize = 2'b11; ReqSigned = ~sg;
    ReqAddr = 32'hFFFF_FFFC; ReqWData = 32'h5555_AAAA;
    lat = 1; nrd = 0; nwr = 0; both = 0; wa = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge Clock);
      if (RespValid) break;
      if (MemoryRead) nrd++;
      if (MemoryWrite) begin nwr++; wa = MemAddress; end
      if (MemoryRead && MemoryWrite) both++;
      @(posedge Clock);
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ".reads"}, 32'(nrd), (exp_lat == 3 || exp_lat == 4) ? 32'd1 : 32'd0);
    check({tag, ".writes"}, 32'(nwr), (exp_lat == 2 || exp_lat == 4) ? 32'd1 : 32'd0);
    check({tag, ".both_strobes"}, 32'(both), 32'd0);
    if (nwr > 0) check({tag, ".wr_addr"}, 32'(wa), {26'b0, addr[7:2]});
    check({tag, ".error"}, 32'(RespError), 32'(exp_err));
    check({tag, ".rdata"}, RespRData, exp_rd);
    held = RespRData;
    for (int h = 0; h < hold; h++) begin
      ReqValid = 1'b1; ReqWrite = 1'b1; ReqSize = 2'b10; ReqAddr = 32'h3C;
      ReqWData = 32'hBAD0_BAD0;
      @(posedge Clock);
      @(negedge Clock);
      check({tag, ".hold_valid"}, 32'(RespValid), 32'd1);
      check({tag, ".hold_rdata"}, RespRData, held);
      check({tag, ".hold_ready"}, 32'(ReqReady), 32'd0);
      check({tag, ".hold_strobe"}, 32'(MemoryRead | MemoryWrite), 32'd0);
    end
    ReqValid = 1'b0;
    RespReady = 1'b1;
    @(posedge Clock);
    #1;
    RespReady = 1'b0;
    @(negedge Clock);
    check({tag, ".idle_valid"}, 32'(RespValid), 32'd0);
    check({tag, ".idle_ready"}, 32'(ReqReady), 32'd1);
    check({tag, ".idle_strobe"}, 32'(MemoryRead | MemoryWrite), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".RespValid"}, 32'(RespValid), 32'd0);
    check({tag, ".RespError"}, 32'(RespError), 32'd0);
    check({tag, ".MemoryRead"}, 32'(MemoryRead), 32'd0);
    check({tag, ".MemoryWrite"}, 32'(MemoryWrite), 32'd0);
    check({tag, ".RespRData"}, RespRData, 32'd0);
    check({tag, ".MemAddress"}, 32'(MemAddress), 32'd0);
    check({tag, ".MemWriteData"}, MemWriteData, 32'd0);
  endtask

  initial begin
    logic        w;
    logic        sg;
    logic        err;
    logic [1:0]  sz;
    logic [1:0]  ln;
    logic [5:0]  idx;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    int          lat;
    int          op;

    for (int i = 0; i < 64; i++) shadow[i] = init_word(6'(i));
    Reset_n = 1'b0; ReqValid = 1'b0; ReqWrite = 1'b0; ReqSize = 2'b00; ReqSigned = 1'b0;
    ReqAddr = '0; ReqWData = '0; RespReady = 1'b0;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    check_reset_outputs("reset");
    Reset_n = 1'b1;
    @(negedge Clock);
    check("reset.ReqReady", 32'(ReqReady), 32'd1);

    // Directed word/byte sequence at word 4.
    do_req("sw_10", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0, 2, 0);
    do_req("lw_10", 1'b0, 2'd2, 1'b1, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF, 3, 0);
    do_req("sb_11", 1'b1, 2'd0, 1'b0, 32'h11, 32'h0000_007A, 1'b0, 32'h0, 4, 0);
    do_req("lw_10b", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD_7AEF, 3, 0);
    do_req("lb_13", 1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 1'b0, 32'hFFFF_FFDE, 3, 0);
    do_req("lbu_13", 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 1'b0, 32'h0000_00DE, 3, 0);
    do_req("lh_12", 1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 1'b0, 32'hFFFF_DEAD, 3, 0);
    shadow[4] = 32'hDEAD_7AEF;

    // Rejected requests.
    do_req("err_half", 1'b0, 2'd1, 1'b0, 32'h11, 32'h0, 1'b1, 32'h0, 1, 0);
    do_req("err_range", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 1'b1, 32'h0, 1, 0);
    do_req("err_size", 1'b0, 2'd3, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0, 1, 0);

    // Response back-pressure with a competing request that must be ignored.
    do_req("hold_lhu", 1'b0, 2'd1, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0000_7AEF, 3, 5);
    do_req("ghost_chk", 1'b0, 2'd2, 1'b0, 32'h3C, 32'h0, 1'b0, 32'hA50F_5AF0, 3, 0);

    // Reset during WAIT of a half store to word 8.
    ReqValid = 1'b1; ReqWrite = 1'b1; ReqSize = 2'd1; ReqSigned = 1'b0;
    ReqAddr = 32'h20; ReqWData = 32'h0000_1234;
    @(posedge Clock);
    #1;
    ReqValid = 1'b0;
    @(negedge Clock);
    check("rst_mid.in_rd", 32'(MemoryRead), 32'd1);
    @(posedge Clock);
    @(negedge Clock);
    check("rst_mid.in_wait", 32'({MemoryRead, MemoryWrite, RespValid}), 32'd0);
    Reset_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    check("rst_mid.no_write", 32'(MemoryWrite), 32'd0);
    Reset_n = 1'b1;
    @(negedge Clock);
    check("rst_mid.ready", 32'(ReqReady), 32'd1);
    check("rst_mid.no_resp", 32'(RespValid), 32'd0);
    do_req("rst_readback", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b0, 32'hA508_5AF7, 3, 0);

    // Mixed traffic against the shadow memory.
    for (int t = 0; t < 40; t++) begin
      op  = int'($urandom_range(0, 9));
      sz  = 2'($urandom_range(0, 2));
      w   = 1'($urandom_range(0, 1));
      sg  = 1'($urandom_range(0, 1));
      wd  = $urandom;
      idx = 6'($urandom_range(0, 63));
      ln  = 2'($urandom_range(0, 3));
      if (op < 8) begin
        if (sz == 2'd1) ln[0] = 1'b0;
        if (sz == 2'd2) ln = 2'd0;
      end
      if (op == 9) sz = 2'd3;
      a = {24'b0, idx, ln};
      if (op == 7) a = a | 32'h100;
      err = ref_err(sz, a);
      if (err)              lat = 1;
      else if (!w)          lat = 3;
      else if (sz == 2'd2)  lat = 2;
      else                  lat = 4;
      exp_rd = (err || w) ? 32'h0 : ref_load(shadow[idx], ln, sz, sg);
      if (!err && w) shadow[idx] = ref_store(shadow[idx], wd, ln, sz);
      do_req($sformatf("rnd%0d", t), w, sz, sg, a, wd, err, exp_rd, lat, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
